// File: rtl/adc_capture_buffer_pkg.sv
// Shared definitions for the ADC capture buffer: default widths, beat/sample
// packing constants and the capture state encoding.
package adc_capture_buffer_pkg;

    localparam int AXIS_DATA_WIDTH_DEF    = 256;
    localparam int ADC_DATA_WIDTH_DEF     = 16;
    localparam int ADC_ADDRESS_WIDTH_DEF  = 14;

    localparam int SAMPLES_PER_BEAT       = AXIS_DATA_WIDTH_DEF / ADC_DATA_WIDTH_DEF;
    localparam int SAMPLES_PER_BEAT_WIDTH = $clog2(SAMPLES_PER_BEAT);
    localparam int RAW                    = ADC_ADDRESS_WIDTH_DEF - SAMPLES_PER_BEAT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } capState_t;

endpackage

// File: rtl/adc_capture_buffer_dpram.sv
// Single-clock capture RAM: one full stream beat written per cycle, read back
// one sample at a time through two register stages (word, then sample mux).
module adc_capture_buffer_dpram #(
    parameter int WRITE_DATA = 256,
    parameter int READ_DATA  = 16,
    parameter int WR_ADDR_W  = 10,
    parameter int SEL_W      = 4
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  wrEn,
    input  logic [WR_ADDR_W-1:0]  wrAddr,
    input  logic [WRITE_DATA-1:0] wrData,
    input  logic [WR_ADDR_W-1:0]  rdWordAddr,
    input  logic [SEL_W-1:0]      rdSel,
    output logic [READ_DATA-1:0]  rdData
);

    localparam int DEPTH = 1 << WR_ADDR_W;

    logic [WRITE_DATA-1:0] mem [DEPTH];
    logic [WRITE_DATA-1:0] rdWord;
    logic [SEL_W-1:0]      rdSelD;

    // Beat-wide write port; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // Read stage 1: fetch the addressed word (old contents on a same-cycle write).
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdWord <= '0;
            rdSelD <= '0;
        end else begin
            rdWord <= mem[rdWordAddr];
            rdSelD <= rdSel;
        end
    end

    // Read stage 2: pick the requested sample out of the registered word.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) rdData <= '0;
        else       rdData <= rdWord[rdSelD*READ_DATA +: READ_DATA];
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// ADC capture buffer: arms on software request, starts at the heartbeat rising
// edge, stores a programmed number of stream beats and serves sample readback.
module adc_capture_buffer
    import adc_capture_buffer_pkg::*;
#(
    parameter int  AXIS_DATA_WIDTH   = AXIS_DATA_WIDTH_DEF,
    parameter int  ADC_DATA_WIDTH    = ADC_DATA_WIDTH_DEF,
    parameter int  ADC_ADDRESS_WIDTH = ADC_ADDRESS_WIDTH_DEF,
    localparam int SPB_W             = $clog2(AXIS_DATA_WIDTH / ADC_DATA_WIDTH),
    localparam int RAW_W             = ADC_ADDRESS_WIDTH - SPB_W
) (
    input  logic                         axis_CLK,
    input  logic                         axis_RESETn,
    input  logic [AXIS_DATA_WIDTH-1:0]   axis_TDATA,
    input  logic                         axis_TVALID,
    output logic                         axis_TREADY,
    input  logic                         hbMarker,
    input  logic                         csrArm,
    input  logic                         csrAbort,
    input  logic [RAW_W-1:0]             csrLastIdx,
    input  logic [ADC_ADDRESS_WIDTH-1:0] rdAddr,
    output logic [ADC_DATA_WIDTH-1:0]    rdData,
    output logic [1:0]                   csrState,
    output logic [15:0]                  csrGapCount
);

    capState_t        state, stateNext;
    logic             hbSync1, hbSync2, hbSyncD1, hbStart;
    logic [RAW_W-1:0] wrIdx, lastIdx;
    logic [15:0]      gapCount;
    logic             armLatch, wrEn, gapInc, lastBeat;

    assign hbStart     = hbSync2 & ~hbSyncD1;
    assign lastBeat    = (wrIdx == lastIdx);
    assign csrState    = state;
    assign csrGapCount = gapCount;

    // Two-flop synchronizer plus one history stage for rising-edge detection.
    always_ff @(posedge axis_CLK or negedge axis_RESETn) begin
        if (!axis_RESETn) begin
            hbSync1  <= 1'b0;
            hbSync2  <= 1'b0;
            hbSyncD1 <= 1'b0;
        end else begin
            hbSync1  <= hbMarker;
            hbSync2  <= hbSync1;
            hbSyncD1 <= hbSync2;
        end
    end

    // The sink always accepts once out of reset.
    always_ff @(posedge axis_CLK or negedge axis_RESETn) begin
        if (!axis_RESETn) axis_TREADY <= 1'b0;
        else              axis_TREADY <= 1'b1;
    end

    // Capture state register.
    always_ff @(posedge axis_CLK or negedge axis_RESETn) begin
        if (!axis_RESETn) state <= ST_IDLE;
        else              state <= stateNext;
    end

    // Next state and datapath controls; abort overrides everything else.
    always_comb begin
        stateNext = state;
        armLatch  = 1'b0;
        wrEn      = 1'b0;
        gapInc    = 1'b0;
        if (csrAbort) begin
            stateNext = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (csrArm) begin
                        stateNext = ST_ARMED;
                        armLatch  = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (hbStart) begin
                        stateNext = ST_CAPTURE;
                        if (axis_TVALID) begin
                            wrEn = 1'b1;
                            if (lastBeat) stateNext = ST_DONE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (axis_TVALID) begin
                        wrEn = 1'b1;
                        if (lastBeat) stateNext = ST_DONE;
                    end else begin
                        gapInc = 1'b1;
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    // Write index, gap counter and latched beat limit; index stops at the limit.
    always_ff @(posedge axis_CLK or negedge axis_RESETn) begin
        if (!axis_RESETn) begin
            wrIdx    <= '0;
            lastIdx  <= '0;
            gapCount <= '0;
        end else if (armLatch) begin
            wrIdx    <= '0;
            lastIdx  <= csrLastIdx;
            gapCount <= '0;
        end else begin
            if (wrEn && !lastBeat)                 wrIdx    <= wrIdx + 1'b1;
            if (gapInc && (gapCount != 16'hFFFF))  gapCount <= gapCount + 16'd1;
        end
    end

    adc_capture_buffer_dpram #(
        .WRITE_DATA (AXIS_DATA_WIDTH),
        .READ_DATA  (ADC_DATA_WIDTH),
        .WR_ADDR_W  (RAW_W),
        .SEL_W      (SPB_W)
    ) uRam (
        .clk        (axis_CLK),
        .rstN       (axis_RESETn),
        .wrEn       (wrEn),
        .wrAddr     (wrIdx),
        .wrData     (axis_TDATA),
        .rdWordAddr (rdAddr[ADC_ADDRESS_WIDTH-1:SPB_W]),
        .rdSel      (rdAddr[SPB_W-1:0]),
        .rdData     (rdData)
    );

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer: directed scenarios, a behavioural capture/RAM
// model compared every cycle, plus literal spot checks.
module tb_adc_capture_buffer;

    localparam int DW = 256, SW = 16, AW = 14, SPB = 16, RAW = 10, NB = 1024;

    logic           clk = 1'b0;
    logic           rstN = 1'b0;
    logic [DW-1:0]  tdata = '0;
    logic           tvalid = 1'b0;
    logic           hb = 1'b0;
    logic           arm = 1'b0;
    logic           abort = 1'b0;
    logic [RAW-1:0] lastIdx = '0;
    logic [AW-1:0]  rdAddr = '0;
    logic           tready;
    logic [SW-1:0]  rdData;
    logic [1:0]     st;
    logic [15:0]    gap;

    int checks = 0;
    int failures = 0;

    adc_capture_buffer dut (
        .axis_CLK    (clk),
        .axis_RESETn (rstN),
        .axis_TDATA  (tdata),
        .axis_TVALID (tvalid),
        .axis_TREADY (tready),
        .hbMarker    (hb),
        .csrArm      (arm),
        .csrAbort    (abort),
        .csrLastIdx  (lastIdx),
        .rdAddr      (rdAddr),
        .rdData      (rdData),
        .csrState    (st),
        .csrGapCount (gap)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [DW-1:0] memM [NB];
    bit            memKnown [NB];
    int            mState = 0, mGap = 0, mIdx = 0, mLast = 0;
    bit            mTready = 1'b0;
    bit            hbHist [3];          // [0] = last sampled hbMarker
    logic [SW-1:0] rd1 = '0, rd2 = '0;  // expected read value after 1 and 2 edges
    bit            k1 = 1'b1, k2 = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ramp(input int base, input int b);
        logic [DW-1:0] r;
        for (int k = 0; k < SPB; k++) r[k*SW +: SW] = 16'(base + b*SPB + k);
        return r;
    endfunction

    task automatic modelReset();
        mState = 0; mGap = 0; mTready = 1'b0;
        for (int i = 0; i < 3; i++) hbHist[i] = 1'b0;
        rd1 = '0; rd2 = '0; k1 = 1'b1; k2 = 1'b1;
    endtask

    task automatic writeBeat();
        memM[mIdx] = tdata;
        memKnown[mIdx] = 1'b1;
        if (mIdx == mLast) mState = 3;
        else               mIdx++;
    endtask

    // One clock edge of the model: read sees contents before this edge's write.
    task automatic modelEdge();
        logic [DW-1:0] w;
        bit start;
        int wi;
        rd2 = rd1; k2 = k1;
        wi = int'(rdAddr) / SPB;
        w  = memM[wi];
        k1 = memKnown[wi];
        rd1 = w[(int'(rdAddr) % SPB)*SW +: SW];
        // start = marker seen high two edges ago and low three edges ago
        start = hbHist[1] && !hbHist[2];
        hbHist[2] = hbHist[1]; hbHist[1] = hbHist[0]; hbHist[0] = hb;
        mTready = 1'b1;
        if (abort) mState = 0;
        else case (mState)
            0, 3: if (arm) begin
                mState = 1; mIdx = 0; mGap = 0; mLast = int'(lastIdx);
            end
            1: if (start) begin
                mState = 2;
                if (tvalid) writeBeat();
            end
            2: begin
                if (tvalid)            writeBeat();
                else if (mGap < 65535) mGap++;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstN) modelEdge();
        @(negedge clk);
    endtask

    task automatic pulseArm(input int li);
        lastIdx = RAW'(li); arm = 1'b1; tick(); arm = 1'b0;
    endtask

    // Leaves hbMarker high so that the next tick() is the start edge.
    task automatic hbRise();
        hb = 1'b0;
        repeat (4) tick();
        hb = 1'b1;
        repeat (2) tick();
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic v);
        tdata = d; tvalid = v; tick(); tvalid = 1'b0;
    endtask

    task automatic readLit(input int a, input int exp, input string name);
        rdAddr = AW'(a); tick(); tick();
        chk(name, 32'(rdData), 32'(exp));
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin rdAddr = AW'(a); tick(); end
        tick(); tick();
    endtask

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        chk("state", 32'(st), 32'(mState));
        chk("gapCount", 32'(gap), 32'(mGap));
        chk("tready", 32'(tready), 32'(mTready));
        if (k2) chk("rdData", 32'(rdData), 32'(rd2));
    end

    initial begin
        // Reset
        repeat (3) tick();
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_gap", 32'(gap), 32'd0);
        chk("rst_rdData", 32'(rdData), 32'd0);
        rstN = 1'b1;
        tick();
        chk("tready_up", 32'(tready), 32'd1);

        // Basic 4-beat capture of a ramp
        pulseArm(3);
        chk("armed", 32'(st), 32'd1);
        hbRise();
        for (int b = 0; b < 4; b++) begin
            beat(ramp(0, b), 1'b1);
            if (b == 2) chk("cap_before_last", 32'(st), 32'd2);
        end
        chk("done1", 32'(st), 32'd3);
        chk("gap1", 32'(gap), 32'd0);
        sweep(0, 63);
        readLit(17, 17, "rd17");
        readLit(63, 63, "rd63");

        // Capture with a 5-cycle gap
        pulseArm(3);
        hbRise();
        beat(ramp(1000, 0), 1'b1);
        beat(ramp(1000, 1), 1'b1);
        repeat (5) beat('0, 1'b0);
        beat(ramp(1000, 2), 1'b1);
        beat(ramp(1000, 3), 1'b1);
        chk("done2", 32'(st), 32'd3);
        chk("gap2", 32'(gap), 32'd5);
        sweep(0, 63);
        readLit(40, 1040, "rd40_gap");

        // Marker edge in IDLE is ignored; marker in CAPTURE has no effect
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_done", 32'(st), 32'd0);
        hb = 1'b1;
        repeat (4) tick();
        pulseArm(2);
        tdata = ramp(2000, 9); tvalid = 1'b1;
        repeat (5) tick();
        tvalid = 1'b0;
        chk("no_start_on_level", 32'(st), 32'd1);
        hbRise();
        beat(ramp(2000, 0), 1'b1);
        hb = 1'b0;
        repeat (3) beat('0, 1'b0);
        hb = 1'b1;
        repeat (3) beat('0, 1'b0);
        beat(ramp(2000, 1), 1'b1);
        beat(ramp(2000, 2), 1'b1);
        chk("done3", 32'(st), 32'd3);
        readLit(47, 2047, "rd47_hb");

        // Abort on the start edge, abort mid-capture, arm+abort together
        pulseArm(5);
        hbRise();
        abort = 1'b1; tdata = ramp(3000, 0); tvalid = 1'b1;
        tick();
        abort = 1'b0; tvalid = 1'b0;
        chk("abort_on_start", 32'(st), 32'd0);
        readLit(0, 2000, "no_write_on_abort");
        pulseArm(5);
        hbRise();
        beat(ramp(3000, 0), 1'b1);
        beat(ramp(3000, 1), 1'b1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_mid", 32'(st), 32'd0);
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("arm_abort", 32'(st), 32'd0);

        // lastIdx = 0: exactly one beat
        pulseArm(0);
        hbRise();
        beat(ramp(4000, 0), 1'b1);
        chk("done_one", 32'(st), 32'd3);
        beat(ramp(4000, 1), 1'b1);
        beat(ramp(4000, 2), 1'b1);
        readLit(0, 4000, "one_beat");
        readLit(16, 3016, "no_extra_beat");

        // lastIdx = max: fill the whole RAM, nothing after the end
        pulseArm(NB - 1);
        hbRise();
        for (int b = 0; b < NB; b++) begin
            beat(ramp(0, b), 1'b1);
            if (b == NB - 2) chk("full_before_last", 32'(st), 32'd2);
        end
        chk("done_full", 32'(st), 32'd3);
        repeat (3) beat(ramp(7, 0), 1'b1);
        readLit(16383, 16383, "rd_last_sample");
        readLit(0, 0, "rd_first_full");
        for (int i = 0; i < 40; i++) begin rdAddr = AW'($urandom_range(0, 16383)); tick(); end
        tick(); tick();

        // Asynchronous reset mid-capture
        pulseArm(20);
        hbRise();
        repeat (3) beat(ramp(5000, 0), 1'b1);
        beat('0, 1'b0);
        beat(ramp(5000, 1), 1'b1);
        #2 rstN = 1'b0;
        #1;
        chk("arst_state", 32'(st), 32'd0);
        chk("arst_tready", 32'(tready), 32'd0);
        chk("arst_gap", 32'(gap), 32'd0);
        chk("arst_rdData", 32'(rdData), 32'd0);
        modelReset();
        tvalid = 1'b1; tdata = ramp(6000, 0);
        repeat (3) tick();
        rstN = 1'b1;
        repeat (6) tick();
        tvalid = 1'b0;
        chk("idle_after_rst", 32'(st), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
